bact_pool_collector: RTL and testbench
======================================

# bact_pool_collector

Consumes the raster-order stream of 4-bit XNOR-popcount results produced by the binary convolution stage. It re-binarizes each result against a majority threshold and applies 2x2 max-pooling (OR of binary values) using a half-width line buffer. It assembles the pooled binary feature map that feeds the next BNN layer, and signals completion with a one-cycle `done` pulse.

## Interface
- `IN_H`, default 26: conv output rows; must be even.
- `IN_W`, default 26: conv output columns; must be even.
- `CNT_W`, default 4: popcount width.
- `THRESH`, default 5: binarization threshold; bit = (popcount >= THRESH).
- `P_H` / `P_W`: derived, IN_H/2 and IN_W/2; not overridable.

- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begins a frame when in IDLE.
- `in_valid`  in  1  popcount beat valid.
- `in_ready`  out  1  collector accepts a beat this cycle.
- `in_data`  in  CNT_W  popcount value, unsigned.
- `layer_o`  out  [P_H-1:0][P_W-1:0]  pooled binary map, registered.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse at frame end.

## Operation
- A beat is accepted on a rising edge where `in_valid && in_ready`.
- FSM states and transitions:
  - IDLE: `in_ready=0`. On `start=1`: clear row counter r, column counter c, line buffer (P_W bits) and `layer_o`, then go to RUN.
  - RUN: `in_ready=1`. On each accepted beat:
    - Compute b = (in_data >= THRESH).
    - Even r: linebuf[c/2] <= (c even) ? b : linebuf[c/2] | b.
    - Odd r, even c: linebuf[c/2] <= linebuf[c/2] | b.
    - Odd r, odd c: layer_o[r/2][c/2] <= linebuf[c/2] | b.
    - Advance c; when c wraps IN_W-1 -> 0, increment r.
    - On the beat with r=IN_H-1 and c=IN_W-1, go to DONE.
  - DONE: `done=1` for exactly one cycle, then go to IDLE unconditionally.
- `start` is ignored in RUN and DONE. `start` arriving in IDLE on the cycle after DONE starts a new frame normally.
- `layer_o` holds its value from the end of a frame until the next accepted `start` or reset.
- Comparison is unsigned and full-width. THRESH=0 forces all ones; THRESH > 2^CNT_W-1 forces all zeros.
- `in_data` is don't-care when `in_valid=0`. Gaps in `in_valid` stall the counters with no state change.

## Timing
- Reset values: state=IDLE, `in_ready=0`, `busy=0`, `done=0`, `layer_o`=all zeros, counters and line buffer all zeros.
- Reset asserted mid-frame aborts the frame immediately. No `done` is produced and `layer_o` is zeroed.
- `in_ready` and `busy` are decoded from the registered state only; there is no combinational path from any input.
- A pooled bit is visible on `layer_o` the cycle after the edge that accepts its bottom-right pixel.
- `done` is high the cycle after the final beat is accepted. `in_ready` is low that same cycle.
- Throughput is 1 beat/cycle. Minimum frame time is IN_H*IN_W accepted cycles, plus 1 cycle for DONE and 1 cycle for the start in IDLE.

## Structure
- Shared package `bnn_pkg`:
  - `CNT_W`
  - default conv output dimensions (26x26)
  - `THRESH_MAJ9 = 5`
  - state typedef `pool_state_t` {IDLE, RUN, DONE}
- One sub-module, `bpool_linebuf`, holds the P_W-bit buffer:
  - inputs: clear, write-enable, index, mode (load/OR)
  - output: the read value at that index
- Row/column counters, FSM and the `layer_o` write stay in the top module.

## Test plan
- Default params; start, then 676 beats all `in_data=9`, back-to-back -> `layer_o` all ones, `done` high for exactly 1 cycle the cycle after beat 676.
- 676 beats all 0 -> `layer_o` all zeros, `done` pulses once.
- Single beat at (r=3,c=5) = 7, all others 0 -> only `layer_o[1][2]=1`.
- Threshold boundary: pixel (0,0)=5 and pixel (2,2)=4, rest 0 -> `layer_o[0][0]=1`, `layer_o[1][1]=0`.
- Random `in_valid` gaps (~50% duty) with a random frame -> `layer_o` matches the reference model. `start` pulsed mid-RUN is ignored.
- Assert `rst` after 300 beats -> `layer_o` zero, `busy=0`, no `done`. A new start plus a full frame of 9s -> all ones.

Source files
------------

// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the binary-network pooling/collector blocks:
//   - CNT_W          : width of the XNOR-popcount values from the conv stage
//   - CONV_H/CONV_W  : default conv output dimensions (26x26)
//   - THRESH_MAJ9    : majority threshold for a 3x3 (9-input) popcount
//   - pool_state_t   : collector FSM states
//   - lb_mode_t      : line-buffer write mode (load or OR-accumulate)
//   - binarize()     : unsigned, full-width threshold compare
// -----------------------------------------------------------------------------
package bnn_pkg;

  localparam int CNT_W       = 4;
  localparam int CONV_H      = 26;
  localparam int CONV_W      = 26;
  localparam int THRESH_MAJ9 = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pool_state_t;

  typedef enum logic {
    LB_LOAD = 1'b0,
    LB_OR   = 1'b1
  } lb_mode_t;

  // Both operands are widened to 32 bits so that a threshold larger than the
  // largest popcount simply yields 0, and a threshold of 0 always yields 1.
  function automatic logic binarize(input logic [31:0] value,
                                    input logic [31:0] thresh);
    return (value >= thresh);
  endfunction

endpackage

// File: rtl/bpool_linebuf.sv
// -----------------------------------------------------------------------------
// bpool_linebuf
// Half-width line buffer for 2x2 binary max-pooling. One bit per pooled
// column holds the OR of the pixels seen so far in the current 2x2 window.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset (clears the buffer)
//   clear   in   synchronous clear of the whole buffer (frame start)
//   we      in   write enable for entry idx
//   idx     in   pooled column index (c/2)
//   mode    in   LB_LOAD: entry <= din ; LB_OR: entry <= entry | din
//   din     in   binarized pixel
//   rd_bit  out  current value of entry idx (combinational read)
// -----------------------------------------------------------------------------
module bpool_linebuf
  import bnn_pkg::*;
#(
  parameter  int P_W   = 13,
  localparam int IDX_W = (P_W > 1) ? $clog2(P_W) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  lb_mode_t         mode,
  input  logic             din,
  output logic             rd_bit
);

  logic [P_W-1:0] lb;

  // NOTE: this buffer is only P_W flops, so it is reset along with the rest
  // of the state; a large RAM-style array would be cleared by logic instead.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lb <= '0;
    end else if (clear) begin
      lb <= '0;
    end else if (we) begin
      lb[idx] <= (mode == LB_LOAD) ? din : (lb[idx] | din);
    end
  end

  assign rd_bit = lb[idx];

endmodule

// File: rtl/bact_pool_collector.sv
// -----------------------------------------------------------------------------
// bact_pool_collector
// Consumes the raster-order stream of popcount results from the binary conv
// stage, re-binarizes each against THRESH and 2x2 max-pools (OR) the binary
// values into a registered P_H x P_W feature map. A one-cycle done pulse
// marks the end of each frame.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset; aborts any frame
//   start     in   begins a frame when IDLE (ignored in RUN/DONE)
//   in_valid  in   popcount beat valid
//   in_ready  out  high in RUN (decoded from state register)
//   in_data   in   popcount, unsigned, CNT_W bits
//   layer_o   out  pooled binary map [P_H-1:0][P_W-1:0], registered
//   busy      out  high in RUN
//   done      out  high for the single DONE cycle
// -----------------------------------------------------------------------------
module bact_pool_collector
  import bnn_pkg::*;
#(
  parameter  int          IN_H   = bnn_pkg::CONV_H,
  parameter  int          IN_W   = bnn_pkg::CONV_W,
  parameter  int          CNT_W  = bnn_pkg::CNT_W,
  parameter  int unsigned THRESH = bnn_pkg::THRESH_MAJ9,
  localparam int          P_H    = IN_H / 2,
  localparam int          P_W    = IN_W / 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CNT_W-1:0]          in_data,
  output logic [P_H-1:0][P_W-1:0]   layer_o,
  output logic                      busy,
  output logic                      done
);

  localparam int RW   = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int CW   = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int PR_W = (P_H > 1) ? $clog2(P_H) : 1;
  localparam int PC_W = (P_W > 1) ? $clog2(P_W) : 1;

  localparam logic [RW-1:0] R_LAST = RW'(IN_H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(IN_W - 1);

  pool_state_t state;
  logic [RW-1:0] r;
  logic [CW-1:0] c;

  logic            accept;
  logic            pix_bit;
  logic [PR_W-1:0] prow;
  logic [PC_W-1:0] pcol;
  logic            lb_clear;
  logic            lb_we;
  lb_mode_t        lb_mode;
  logic            lb_rd;

  // Handshake outputs depend on the state register only.
  assign in_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  assign accept  = in_valid && in_ready;
  assign pix_bit = binarize(32'(in_data), 32'(THRESH));
  assign prow    = PR_W'(r >> 1);
  assign pcol    = PC_W'(c >> 1);

  // Line-buffer control. The top-left pixel of a window loads its entry,
  // the top-right and bottom-left pixels OR into it, and the bottom-right
  // pixel bypasses the buffer straight into layer_o.
  // NOTE: every combinationally driven signal gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    lb_clear = 1'b0;
    lb_we    = 1'b0;
    lb_mode  = LB_OR;
    if (state == IDLE && start) begin
      lb_clear = 1'b1;
    end
    if (accept && !(r[0] && c[0])) begin
      lb_we = 1'b1;
    end
    if (!r[0] && !c[0]) begin
      lb_mode = LB_LOAD;
    end
  end

  bpool_linebuf #(
    .P_W (P_W)
  ) u_linebuf (
    .clk    (clk),
    .rst    (rst),
    .clear  (lb_clear),
    .we     (lb_we),
    .idx    (pcol),
    .mode   (lb_mode),
    .din    (pix_bit),
    .rd_bit (lb_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      r       <= '0;
      c       <= '0;
      layer_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            r       <= '0;
            c       <= '0;
            layer_o <= '0;
            state   <= RUN;
          end
        end

        RUN: begin
          if (accept) begin
            if (r[0] && c[0]) begin
              layer_o[prow][pcol] <= lb_rd | pix_bit;
            end
            if (c == C_LAST) begin
              c <= '0;
              if (r == R_LAST) begin
                r     <= '0;
                state <= DONE;
              end else begin
                r <= r + 1'b1;
              end
            end else begin
              c <= c + 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bact_pool_collector.sv
// -----------------------------------------------------------------------------
// tb_bact_pool_collector
// Scoreboard bench: the driver pushes the expected pooled map and the cycle
// on which done must appear when it issues the final beat of a frame; the
// monitor pops and compares whenever the DUT raises done.
// -----------------------------------------------------------------------------
module tb_bact_pool_collector;
  import bnn_pkg::*;

  localparam int IN_H = 26;
  localparam int IN_W = 26;
  localparam int P_H  = IN_H / 2;
  localparam int P_W  = IN_W / 2;
  localparam int NPIX = IN_H * IN_W;

  typedef logic [P_H-1:0][P_W-1:0] map_t;
  typedef struct {
    map_t layer;
    int   cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       done;
  map_t       layer_o;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  exp_t sb[$];
  logic done_q = 1'b0;
  logic [3:0] frame [IN_H][IN_W];

  bact_pool_collector dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .layer_o  (layer_o),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: OR of the four binarized pixels of each window.
  function automatic map_t model();
    map_t m;
    for (int i = 0; i < P_H; i++)
      for (int j = 0; j < P_W; j++)
        m[i][j] = (frame[2*i][2*j]   >= 4'd5) || (frame[2*i][2*j+1]   >= 4'd5) ||
                  (frame[2*i+1][2*j] >= 4'd5) || (frame[2*i+1][2*j+1] >= 4'd5);
    return m;
  endfunction

  task automatic fill(input logic [3:0] v);
    for (int i = 0; i < IN_H; i++)
      for (int j = 0; j < IN_W; j++)
        frame[i][j] = v;
  endtask

  // Monitor: compares on every done, flags unexpected or stretched pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        check("done_single_cycle", 256'(done_q), 256'(0));
        check("ready_low_in_done", 256'(in_ready), 256'(0));
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_cycle", 256'(cyc), 256'(e.cyc));
          check("layer_at_done", 256'(layer_o), 256'(e.layer));
        end
      end
      done_q = done;
    end else begin
      done_q = 1'b0;
    end
  end

  // Drives start until RUN, then n_beats pixels in raster order.
  task automatic run_frame(input bit gaps, input int n_beats,
                           input bit poke_start, input map_t exp_map);
    int guard;
    logic acc;
    start = 1'b1;
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (!busy && guard < 10);
    start = 1'b0;
    check("busy_after_start", 256'(busy), 256'(1));
    if (!busy) return;
    for (int k = 0; k < n_beats; k++) begin
      guard = 0;
      forever begin
        in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = in_valid ? frame[k / IN_W][k % IN_W] : 4'($urandom_range(0, 15));
        if (poke_start && k == 100) start = 1'b1;
        acc = in_valid && in_ready;
        if (acc && k == NPIX - 1) sb.push_back('{layer: exp_map, cyc: cyc + 1});
        @(posedge clk); #1;
        start = 1'b0;
        if (acc) break;
        guard++;
        if (guard > 50) begin
          check("stall_timeout", 256'(in_ready), 256'(1));
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  // Bounded wait for the monitor to consume the pending expectation, then
  // confirm the map holds while idle.
  task automatic finish_frame(input map_t exp_map);
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check("done_seen", 256'(sb.size()), 256'(0));
    sb.delete();
    repeat (3) @(negedge clk);
    check("layer_hold_idle", 256'(layer_o), 256'(exp_map));
    check("busy_idle", 256'(busy), 256'(0));
  endtask

  initial begin
    map_t e;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'd0;
    #12;
    check("rst_layer", 256'(layer_o), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_ready", 256'(in_ready), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // All 9s, back-to-back: every window above threshold.
    fill(4'd9);
    e = '1;
    run_frame(1'b0, NPIX, 1'b0, e);
    finish_frame(e);

    // All zeros: map cleared at start and stays zero.
    fill(4'd0);
    e = '0;
    run_frame(1'b0, NPIX, 1'b0, e);
    finish_frame(e);

    // Single hot pixel at (3,5) lands in window (1,2).
    fill(4'd0);
    frame[3][5] = 4'd7;
    e = '0;
    e[1][2] = 1'b1;
    run_frame(1'b0, NPIX, 1'b0, e);
    finish_frame(e);

    // Threshold boundary: 5 passes, 4 fails; last pixel of frame also hot.
    fill(4'd0);
    frame[0][0]   = 4'd5;
    frame[2][2]   = 4'd4;
    frame[25][25] = 4'd15;
    e = '0;
    e[0][0]   = 1'b1;
    e[12][12] = 1'b1;
    run_frame(1'b0, NPIX, 1'b0, e);
    finish_frame(e);

    // Random frame with valid gaps and a start pulse mid-RUN.
    for (int i = 0; i < IN_H; i++)
      for (int j = 0; j < IN_W; j++)
        frame[i][j] = 4'($urandom_range(0, 15));
    e = model();
    run_frame(1'b1, NPIX, 1'b1, e);
    finish_frame(e);

    // Reset mid-frame: no done, map zeroed, then a full frame recovers.
    fill(4'd9);
    run_frame(1'b0, 300, 1'b0, '1);
    rst = 1'b1;
    #2;
    check("abort_layer", 256'(layer_o), 256'(0));
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_done", 256'(done), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_abort_idle", 256'(busy), 256'(0));
    @(posedge clk); #1;
    e = '1;
    run_frame(1'b0, NPIX, 1'b0, e);
    finish_frame(e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
